// File: rtl/zube_wb_pkg.sv
// Shared types and defaults for the Zube Wishbone two-master arbiter.
package zube_wb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   localparam int unsigned         DEFAULT_TIMEOUT  = 255;
   localparam logic [DATA_W-1:0]   DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   // One master's request as seen by the shared slave port.
   typedef struct packed {
      logic              cyc;
      logic              stb;
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/zube_wb_watchdog.sv
// Saturating wait counter; expire marks the cycle the count reaches TIMEOUT.
module zube_wb_watchdog
   import zube_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset_b,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LIMIT   = (TIMEOUT > 255) ? CNT_MAX : CNT_W'(TIMEOUT);
   localparam logic             ENABLED = (TIMEOUT != 0);

   logic [CNT_W-1:0] count;

   assign expire = ENABLED & run & (count == LIMIT);

   // Expiry restarts the count so a stalled master sees one error ack per window.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (run && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/zube_wb_arbiter.sv
// Round-robin arbiter giving the management core and the external bridge
// shared access to one Zube Wishbone slave, with a stalled-ack watchdog.
module zube_wb_arbiter
   import zube_wb_pkg::*;
#(
   parameter int unsigned       TIMEOUT  = DEFAULT_TIMEOUT,
   parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              m0_cyc_in,
   input  logic              m0_stb_in,
   input  logic              m0_we_in,
   input  logic [DATA_W-1:0] m0_addr_in,
   input  logic [DATA_W-1:0] m0_data_in,
   output logic              m0_ack_out,
   output logic [DATA_W-1:0] m0_data_out,
   input  logic              m1_cyc_in,
   input  logic              m1_stb_in,
   input  logic              m1_we_in,
   input  logic [DATA_W-1:0] m1_addr_in,
   input  logic [DATA_W-1:0] m1_data_in,
   output logic              m1_ack_out,
   output logic [DATA_W-1:0] m1_data_out,
   output logic              s_cyc_out,
   output logic              s_stb_out,
   output logic              s_we_out,
   output logic [DATA_W-1:0] s_addr_out,
   output logic [DATA_W-1:0] s_data_out,
   input  logic              s_ack_in,
   input  logic [DATA_W-1:0] s_data_in,
   output logic              timeout_irq_out
);

   state_t            state, state_nxt;
   logic              last_grant, last_grant_nxt;
   wb_req_t           m0_req, m1_req, sel_req;
   logic              req0, req1;
   logic              run, clear, expire;
   logic              resp_ack;
   logic [DATA_W-1:0] resp_data;

   assign m0_req = {m0_cyc_in, m0_stb_in, m0_we_in, m0_addr_in, m0_data_in};
   assign m1_req = {m1_cyc_in, m1_stb_in, m1_we_in, m1_addr_in, m1_data_in};
   assign req0   = m0_cyc_in & m0_stb_in;
   assign req1   = m1_cyc_in & m1_stb_in;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // last_grant names the master that won most recently; a tie goes to the other one.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last_grant)) begin
               state_nxt      = GRANT0;
               last_grant_nxt = 1'b0;
            end else if (req1) begin
               state_nxt      = GRANT1;
               last_grant_nxt = 1'b1;
            end
         end
         GRANT0:  if (!m0_cyc_in) state_nxt = IDLE;
         GRANT1:  if (!m1_cyc_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Granted master's request, squashed as soon as it lets go of cyc.
   always_comb begin
      sel_req = '0;
      case (state)
         GRANT0:  sel_req = m0_req;
         GRANT1:  sel_req = m1_req;
         default: sel_req = '0;
      endcase
      if (!sel_req.cyc) sel_req = '0;
   end

   assign run   = sel_req.cyc & sel_req.stb & ~s_ack_in;
   assign clear = (state == IDLE) | s_ack_in;

   zube_wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset_b (reset_b),
      .clear   (clear),
      .run     (run),
      .expire  (expire)
   );

   always_comb begin
      s_cyc_out       = sel_req.cyc;
      s_stb_out       = sel_req.stb & ~expire;
      s_we_out        = sel_req.we;
      s_addr_out      = sel_req.addr;
      s_data_out      = sel_req.data;
      timeout_irq_out = expire;

      resp_ack  = sel_req.cyc & (s_ack_in | expire);
      resp_data = '0;
      if (sel_req.cyc) resp_data = expire ? ERR_DATA : s_data_in;

      m0_ack_out  = 1'b0;
      m0_data_out = '0;
      m1_ack_out  = 1'b0;
      m1_data_out = '0;
      if (state == GRANT0) begin
         m0_ack_out  = resp_ack;
         m0_data_out = resp_data;
      end
      if (state == GRANT1) begin
         m1_ack_out  = resp_ack;
         m1_data_out = resp_data;
      end
   end

endmodule

// File: tb/tb_zube_wb_arbiter.sv
// Self-checking bench for zube_wb_arbiter: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_zube_wb_arbiter;

   localparam int unsigned TMO   = 255;
   localparam int          TMO_I = 255;
   localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        s_ack = 1'b0;
   logic [31:0] s_rdata = '0;
   logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, irq;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [133:0] actual;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   zube_wb_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .clk(clk), .reset_b(reset_b),
      .m0_cyc_in(m0_cyc), .m0_stb_in(m0_stb), .m0_we_in(m0_we),
      .m0_addr_in(m0_addr), .m0_data_in(m0_wdata),
      .m0_ack_out(m0_ack), .m0_data_out(m0_rdata),
      .m1_cyc_in(m1_cyc), .m1_stb_in(m1_stb), .m1_we_in(m1_we),
      .m1_addr_in(m1_addr), .m1_data_in(m1_wdata),
      .m1_ack_out(m1_ack), .m1_data_out(m1_rdata),
      .s_cyc_out(s_cyc), .s_stb_out(s_stb), .s_we_out(s_we),
      .s_addr_out(s_addr), .s_data_out(s_wdata),
      .s_ack_in(s_ack), .s_data_in(s_rdata),
      .timeout_irq_out(irq)
   );

   assign actual = {m0_ack, m0_rdata, m1_ack, m1_rdata,
                    s_cyc, s_stb, s_we, s_addr, s_wdata, irq};

   // Reference model: who owns the slave (-1 none), who won last, cycles waited.
   typedef struct packed {
      int owner;
      int last;
      int cnt;
   } mstate_t;

   mstate_t ms = '{owner: -1, last: 1, cnt: 0};

   function automatic logic own_cyc();
      return (ms.owner == 0) ? m0_cyc : (ms.owner == 1) ? m1_cyc : 1'b0;
   endfunction

   function automatic logic own_stb();
      return (ms.owner == 0) ? m0_stb : (ms.owner == 1) ? m1_stb : 1'b0;
   endfunction

   function automatic logic model_expire();
      return own_cyc() && own_stb() && !s_ack && (TMO_I != 0) && (ms.cnt == TMO_I);
   endfunction

   function automatic logic [133:0] model_out();
      logic        act, ex, ack_e, we_e;
      logic [31:0] rd_e, addr_e, wd_e;
      act    = own_cyc();
      ex     = model_expire();
      ack_e  = act && (s_ack || ex);
      rd_e   = !act ? 32'h0 : (ex ? ERR : s_rdata);
      we_e   = act && ((ms.owner == 0) ? m0_we : m1_we);
      addr_e = !act ? 32'h0 : ((ms.owner == 0) ? m0_addr : m1_addr);
      wd_e   = !act ? 32'h0 : ((ms.owner == 0) ? m0_wdata : m1_wdata);
      return {(ms.owner == 0) ? ack_e : 1'b0, (ms.owner == 0) ? rd_e : 32'h0,
              (ms.owner == 1) ? ack_e : 1'b0, (ms.owner == 1) ? rd_e : 32'h0,
              act, act && own_stb() && !ex, we_e, addr_e, wd_e, ex};
   endfunction

   function automatic mstate_t model_next();
      mstate_t n;
      logic r0, r1;
      n  = ms;
      r0 = m0_cyc && m0_stb;
      r1 = m1_cyc && m1_stb;
      if (ms.owner < 0) begin
         if (r0 && r1)  n.owner = (ms.last == 1) ? 0 : 1;
         else if (r0)   n.owner = 0;
         else if (r1)   n.owner = 1;
         if (n.owner >= 0) begin
            n.last = n.owner;
            n.cnt  = 0;
         end
      end else if (!own_cyc()) begin
         n.owner = -1;
      end else if (s_ack || model_expire()) begin
         n.cnt = 0;
      end else if (own_stb() && ms.cnt < 255) begin
         n.cnt = ms.cnt + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_b) begin
      if (!reset_b) ms <= '{owner: -1, last: 1, cnt: 0};
      else          ms <= model_next();
   end

   task automatic idle_inputs();
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      s_ack  = 1'b0;
   endtask

   task automatic do_reset();
      reset_b = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      reset_b = 1'b1;
   endtask

   task automatic test_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      m0_addr = 32'h1111_0000; m1_addr = 32'h2222_0000;
      s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
      @(negedge clk);
      checks++;
      if (actual !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h want=0", actual);
      end
      @(negedge clk);
      checks++;
      if (actual !== '0) begin
         failures++; $display("FAIL reset_hold got=%h want=0", actual);
      end
      idle_inputs();
      reset_b = 1'b1;
      @(negedge clk);
      checks++;
      if (actual !== '0) begin
         failures++; $display("FAIL idle_after_reset got=%h want=0", actual);
      end
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h3000_0004;
      @(negedge clk);
      checks++;
      if (s_stb !== 1'b0) begin
         failures++; $display("FAIL read_not_yet got=%b want=0", s_stb);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_stb, s_we, s_addr} !== {1'b1, 1'b1, 1'b0, 32'h3000_0004}) begin
         failures++;
         $display("FAIL read_strobe got=%b%b%b_%h want=110_30000004", s_cyc, s_stb, s_we, s_addr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (m0_ack !== 1'b0) begin
         failures++; $display("FAIL read_early_ack got=%b want=0", m0_ack);
      end
      @(posedge clk); #1;
      s_ack = 1'b1; s_rdata = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if ({m0_ack, m0_rdata} !== {1'b1, 32'h1234_5678}) begin
         failures++; $display("FAIL read_ack got=%b_%h want=1_12345678", m0_ack, m0_rdata);
      end
      checks++;
      if ({m1_ack, m1_rdata} !== 33'h0) begin
         failures++; $display("FAIL read_other_quiet got=%b_%h want=0_00000000", m1_ack, m1_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({s_cyc, s_stb, m0_ack} !== 3'b000) begin
         failures++; $display("FAIL read_release got=%b%b%b want=000", s_cyc, s_stb, m0_ack);
      end
   endtask

   task automatic test_tie();
      do_reset();
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'hA000_0000;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'hB000_0000;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_addr} !== {1'b1, 32'hA000_0000}) begin
         failures++; $display("FAIL tie_first_m0 got=%b_%h want=1_a0000000", s_cyc, s_addr);
      end
      @(posedge clk); #1;
      m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_stb, m0_ack, m1_ack} !== 4'b0000) begin
         failures++; $display("FAIL tie_drop_falls got=%b%b%b%b want=0000", s_cyc, s_stb, m0_ack, m1_ack);
      end
      @(posedge clk); #1;
      s_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0) begin
         failures++; $display("FAIL tie_idle_gap got=%b want=0", s_cyc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_addr} !== {1'b1, 32'hB000_0000}) begin
         failures++; $display("FAIL tie_then_m1 got=%b_%h want=1_b0000000", s_cyc, s_addr);
      end
      @(posedge clk); #1;
      m1_cyc = 1'b0; m1_stb = 1'b0;
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_addr} !== {1'b1, 32'hA000_0000}) begin
         failures++; $display("FAIL tie_second_m0 got=%b_%h want=1_a0000000", s_cyc, s_addr);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [31:0] datas [4];
      for (int i = 0; i < 4; i++) begin
         addrs[i] = 32'h3000_0100 + 32'(i * 4);
         datas[i] = $urandom;
      end
      @(posedge clk); #1;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
      m1_addr = addrs[0]; m1_wdata = datas[0];
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0BAD;
      for (int i = 0; i < 4; i++) begin
         s_ack = 1'b1; s_rdata = $urandom;
         @(negedge clk);
         checks++;
         if ({s_cyc, s_stb, s_we, s_addr, s_wdata, m1_ack, m0_ack} !==
             {3'b111, addrs[i], datas[i], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_write%0d got=%b%b%b_%h_%h_%b%b want=111_%h_%h_10", i,
                     s_cyc, s_stb, s_we, s_addr, s_wdata, m1_ack, m0_ack, addrs[i], datas[i]);
         end
         @(posedge clk); #1;
         if (i < 3) begin
            m1_addr = addrs[i+1]; m1_wdata = datas[i+1];
         end else begin
            m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if ({s_cyc, m0_ack} !== 2'b00) begin
         failures++; $display("FAIL b2b_drop got=%b%b want=00", s_cyc, m0_ack);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0) begin
         failures++; $display("FAIL b2b_idle_gap got=%b want=0", s_cyc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_we, s_addr} !== {2'b10, 32'h0000_0BAD}) begin
         failures++; $display("FAIL b2b_m0_after got=%b%b_%h want=10_00000bad", s_cyc, s_we, s_addr);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_timeout();
      int hit;
      hit = -1;
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h3000_0008;
      @(posedge clk); #1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (m0_ack) begin
            hit = k;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (hit !== 255) begin
         failures++; $display("FAIL timeout_cycle got=%0d want=255", hit);
      end
      checks++;
      if ({m0_rdata, irq, s_stb, s_cyc, m1_ack} !== {ERR, 4'b1010}) begin
         failures++;
         $display("FAIL timeout_resp got=%h_%b%b%b%b want=deadbeef_1010", m0_rdata, irq, s_stb, s_cyc, m1_ack);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({irq, m0_ack, s_cyc, s_stb} !== 4'b0011) begin
         failures++; $display("FAIL timeout_pulse_hold got=%b%b%b%b want=0011", irq, m0_ack, s_cyc, s_stb);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_ack_at_timeout();
      logic early;
      early = 1'b0;
      @(posedge clk); #1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h3000_000C;
      @(posedge clk); #1;
      for (int k = 0; k < 255; k++) begin
         @(negedge clk);
         if (m0_ack || irq) early = 1'b1;
         @(posedge clk); #1;
      end
      s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
      @(negedge clk);
      checks++;
      if (early !== 1'b0) begin
         failures++; $display("FAIL ack_wins_no_early got=%b want=0", early);
      end
      checks++;
      if ({m0_ack, m0_rdata, irq, s_stb} !== {1'b1, 32'hCAFE_0001, 2'b01}) begin
         failures++;
         $display("FAIL ack_wins got=%b_%h_%b%b want=1_cafe0001_01", m0_ack, m0_rdata, irq, s_stb);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h3000_0200; m1_wdata = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_addr} !== {1'b1, 32'h3000_0200}) begin
         failures++; $display("FAIL rst_mid_granted got=%b_%h want=1_30000200", s_cyc, s_addr);
      end
      #2;
      s_ack = 1'b1; s_rdata = 32'h7777_7777;
      reset_b = 1'b0;
      #1;
      checks++;
      if (actual !== '0) begin
         failures++; $display("FAIL rst_mid_async got=%h want=0", actual);
      end
      @(posedge clk);
      @(negedge clk);
      s_ack = 1'b0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'hA000_0040;
      reset_b = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin
         failures++; $display("FAIL rst_mid_idle got=%b want=0", s_cyc);
      end
      @(negedge clk);
      checks++;
      if ({s_cyc, s_addr} !== {1'b1, 32'hA000_0040}) begin
         failures++; $display("FAIL rst_mid_m0_first got=%b_%h want=1_a0000040", s_cyc, s_addr);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_random();
      logic [133:0] expected;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0);
         else        m0_cyc = ($urandom_range(0, 3) == 0);
         if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0);
         else        m1_cyc = ($urandom_range(0, 3) == 0);
         m0_stb   = ($urandom_range(0, 3) != 0);
         m1_stb   = ($urandom_range(0, 3) != 0);
         m0_we    = 1'($urandom);
         m1_we    = 1'($urandom);
         m0_addr  = $urandom; m0_wdata = $urandom;
         m1_addr  = $urandom; m1_wdata = $urandom;
         s_ack    = ($urandom_range(0, 2) == 0);
         s_rdata  = $urandom;
         @(negedge clk);
         expected = model_out();
         checks++;
         if (actual !== expected) begin
            failures++; $display("FAIL random_cycle%0d got=%h want=%h", n, actual, expected);
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit got=running want=finished");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zube_wb_arbiter.md
ZUBE_WB_ARBITER -- requirements
Module: zube_wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum cycles a granted strobe may wait for slave ack.
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 reset_b  input  1  asynchronous, active-low reset.
REQ-005 m0_cyc_in, m0_stb_in, m0_we_in  input  1 each  master 0 (management core) Wishbone controls.
REQ-006 m0_addr_in, m0_data_in  input  32 each  master 0 address, write data.
REQ-007 m0_ack_out  output  1; m0_data_out  output  32  master 0 ack, read data.
REQ-008 m1_* SHALL mirror REQ-005..007 for master 1 (external bus bridge).
REQ-009 s_cyc_out, s_stb_out, s_we_out  output  1 each; s_addr_out, s_data_out  output  32 each  shared Zube slave port.
REQ-010 s_ack_in  input  1; s_data_in  input  32  slave ack, read data.
REQ-011 timeout_irq_out  output  1  one-cycle pulse per timeout event.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT0, GRANT1, plus a 1-bit last_grant register.
REQ-013 A master SHALL count as requesting when its cyc_in and stb_in are both high.
REQ-014 In IDLE, with only one master requesting, the FSM SHALL enter that master's GRANT state at the next edge.
REQ-015 In IDLE, with both requesting, the FSM SHALL grant the master not in last_grant (round-robin), and SHALL update last_grant on entry to each GRANT state.
REQ-016 Slave outputs SHALL be combinational from the FSM state: in GRANTn, s_cyc/stb/we/addr/data = master n's inputs; in IDLE, s_cyc_out = s_stb_out = 0.
REQ-017 Arbitration latency SHALL be one cycle: a request at edge N appears on the slave port in cycle N+1.
REQ-018 s_ack_in and s_data_in SHALL be routed only to the granted master, gated by that master's cyc_in; the other master's ack SHALL be 0 and its data_out 0.
REQ-019 The grant SHALL be held while the granted master's cyc_in is high, so back-to-back and block transfers are never interleaved.
REQ-020 When the granted master drops cyc_in, its slave outputs SHALL fall in the same cycle, and the FSM SHALL return to IDLE at the next edge; a slave ack in that cycle SHALL be discarded.
REQ-021 An 8-bit wait counter SHALL clear on every grant entry and on s_ack_in, and SHALL increment each cycle the granted strobe is high without ack.
REQ-022 When the counter equals TIMEOUT, for one cycle: the block SHALL assert the granted master's ack with data ERR_DATA, force s_stb_out low, pulse timeout_irq_out, and clear the counter.
REQ-023 If s_ack_in arrives in the same cycle the counter reaches TIMEOUT, the slave ack SHALL win: real data is returned and there is no irq.
REQ-024 The counter SHALL saturate: it does not wrap, and TIMEOUT=0 disables the watchdog.

Reset
REQ-025 reset_b low SHALL immediately force: state IDLE, last_grant=1 (master 0 wins the first tie), counter 0, all s_* outputs 0, both acks 0, both data_out 0, timeout_irq_out 0.
REQ-026 Reset asserted mid-transfer SHALL abort it with no ack to either master.
REQ-027 Reset deassertion SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-028 Shared package zube_wb_pkg SHALL hold the state encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2), the default TIMEOUT and ERR_DATA.
REQ-029 The watchdog counter SHALL be the single sub-module, zube_wb_watchdog (inputs clear/run, output expire); everything else stays flat.

Verification
REQ-030 m0 read of addr 0x3000_0004 alone, slave acks 2 cycles later with 0x1234_5678 -> slave strobe at N+1; m0_ack with 0x1234_5678; m1_ack stays 0.
REQ-031 m0 and m1 request on the same edge after reset -> m0 granted first; m1 granted one cycle after m0 drops cyc; the next tie goes to m0.
REQ-032 m1 holds cyc over 4 back-to-back writes while m0 requests -> m0 is not granted until m1 cyc falls; all 4 writes reach the slave in order.
REQ-033 Slave never acks, TIMEOUT=255 -> after 255 wait cycles m0_ack=1 with 0xDEAD_BEEF, timeout_irq_out pulses exactly 1 cycle, FSM still GRANT0 until cyc drops.
REQ-034 s_ack_in coincides with the counter reaching TIMEOUT -> slave data returned, no irq.
REQ-035 reset_b pulsed low during an m1 transfer -> all outputs 0 asynchronously; after release the FSM is IDLE and m0 wins the first tie.
